// File: rtl/redund_ctrl.sv
// Dual-redundancy failover controller: debounces link status, arbitrates port select and
// defers switchovers to frame boundaries. Optional auto-revert to port 1 via REDUND_REVERT_EN.
module redund_ctrl #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int GUARD_CYCLES    = 1250,
  parameter int MAX_PEND_CYCLES = 250000,
  parameter int REVERT_CYCLES   = 1250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link1,
  input  logic        link2,
  input  logic        busy,
  input  logic        force_en,
  input  logic        force_sel,
  output logic        select,
  output logic        sw_evt,
  output logic [1:0]  state,
  output logic [1:0]  link_db,
  output logic [15:0] switch_cnt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PEND_W = $clog2(MAX_PEND_CYCLES + 1);
  localparam int GRD_W  = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_P1    = 2'b00,
    ST_P2    = 2'b01,
    ST_PEND  = 2'b10,
    ST_GUARD = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DB_W-1:0]   db_cnt [2];
  logic [PEND_W-1:0] pend_cnt;
  logic [GRD_W-1:0]  guard_cnt;
  logic [1:0]        raw;
  logic              want;
  logic              do_switch;
  logic              rev_hit;

  assign raw   = {link2, link1};
  assign state = state_q;

  // Debounce: debounced level follows raw only after DEBOUNCE_CYCLES consecutive differing edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_db <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (raw[i] == link_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          link_db[i] <= raw[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef REDUND_REVERT_EN
  localparam int REV_W = $clog2(REVERT_CYCLES + 1);
  logic [REV_W-1:0] rev_cnt;

  assign rev_hit = (rev_cnt == REV_W'(REVERT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || do_switch || !(select && !force_en && link_db[0])) begin
      rev_cnt <= '0;
    end else if (!rev_hit) begin
      rev_cnt <= rev_cnt + 1'b1;
    end
  end
`else
  assign rev_hit = 1'b0 && (REVERT_CYCLES > 0);
`endif

  always_comb begin
    want = select;
    if (force_en) begin
      want = force_sel;
    end else if (!select) begin
      if (!link_db[0] && link_db[1]) want = 1'b1;
    end else begin
      if ((!link_db[1] && link_db[0]) || rev_hit) want = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    do_switch = 1'b0;
    unique case (state_q)
      ST_P1, ST_P2: begin
        if (want != select) state_d = ST_PEND;
      end
      ST_PEND: begin
        // A cancelled request wins over a boundary or timeout on the same edge.
        if (want == select) begin
          state_d = select ? ST_P2 : ST_P1;
        end else if (!busy || pend_cnt == PEND_W'(MAX_PEND_CYCLES - 1)) begin
          do_switch = 1'b1;
          state_d   = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt == GRD_W'(GUARD_CYCLES - 1)) state_d = select ? ST_P2 : ST_P1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_P1;
      pend_cnt   <= '0;
      guard_cnt  <= '0;
      select     <= 1'b0;
      sw_evt     <= 1'b0;
      switch_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pend_cnt  <= (state_q == ST_PEND && state_d == ST_PEND) ? pend_cnt + 1'b1 : '0;
      guard_cnt <= (state_q == ST_GUARD && state_d == ST_GUARD) ? guard_cnt + 1'b1 : '0;
      select    <= select ^ do_switch;
      sw_evt    <= do_switch;
      if (do_switch && switch_cnt != 16'hFFFF) switch_cnt <= switch_cnt + 16'd1;
    end
  end

endmodule
